seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 2, giving the number of multiplexed digits (range 1..8).
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 25000, giving the clocks each digit is lit per scan slot (minimum 2).
REQ-003 The block SHALL have parameter DEAD_CYCLES, default 250, giving the clocks all digits are off between slots for anti-ghosting (minimum 1).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means segment and digit outputs are inverted (0 = lit).
REQ-005 The block SHALL have one clock and a synchronous, active-low reset, with ports: i_Clk in 1, the single clock; i_Rst_L in 1, the synchronous active-low reset.
REQ-006 The block SHALL have port i_Value in 4*NUM_DIGITS, hex nibbles, where nibble k drives digit k and digit NUM_DIGITS-1 is most significant.
REQ-007 The block SHALL have port i_Load in 1, a single-cycle strobe that captures i_Value into the shadow register.
REQ-008 The block SHALL have port i_Blank_Mask in NUM_DIGITS, where bit k=1 forces digit k dark; it is sampled live, not shadowed.
REQ-009 The block SHALL have port i_LZ_Blank in 1, which enables leading-zero blanking.
REQ-010 The block SHALL have port o_Segments out 7, with bit 6 = segment A through bit 0 = segment G.
REQ-011 The block SHALL have port o_Digit_En out NUM_DIGITS, a one-hot digit enable, or all-inactive.
REQ-012 The block SHALL have port o_Pending out 1, high while the shadow value awaits a frame boundary.
REQ-013 The block SHALL have port o_Frame_Done out 1, a one-cycle pulse at each scan wrap.

Function
REQ-014 The block SHALL use an active-high decode of digit nibbles 0..F to 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47 (hex, A=bit6), and when ACTIVE_LOW=1 SHALL output the bitwise inverse.
REQ-015 The block SHALL implement a two-state FSM with states S_DEAD and S_ON, plus a cycle counter and a digit index idx (width clog2(NUM_DIGITS), minimum 1).
REQ-016 In S_DEAD, the block SHALL hold all o_Digit_En inactive and all o_Segments off, and after DEAD_CYCLES clocks SHALL transition to S_ON with the same idx.
REQ-017 In S_ON, the block SHALL drive only o_Digit_En[idx] active and o_Segments with the decode of display nibble idx, and after REFRESH_CYCLES clocks SHALL transition to S_DEAD with idx+1.
REQ-018 When S_ON with idx=NUM_DIGITS-1 expires, idx SHALL wrap to 0; that edge SHALL be the frame boundary, and o_Frame_Done SHALL be 1 for exactly the following cycle.
REQ-019 The scan period SHALL be exactly NUM_DIGITS*(DEAD_CYCLES+REFRESH_CYCLES) clocks.
REQ-020 An i_Load pulse SHALL copy i_Value into the shadow register and set o_Pending on the next edge.
REQ-021 A further i_Load while o_Pending=1 SHALL overwrite the shadow, and only the last value SHALL be applied.
REQ-022 At the frame boundary with o_Pending=1, the display register SHALL be set to the shadow and o_Pending SHALL clear, so no frame shows mixed values.
REQ-023 If i_Load coincides with the frame boundary edge, the old shadow SHALL be applied, the new i_Value SHALL be captured, and o_Pending SHALL remain 1.
REQ-024 A digit SHALL be dark in S_ON (enable inactive, segments off) if i_Blank_Mask[idx]=1, or if i_LZ_Blank=1, the displayed nibble is 0, idx>0, and every more-significant displayed nibble is 0.
REQ-025 Digit 0 SHALL never be leading-zero blanked.
REQ-026 o_Segments and o_Digit_En SHALL be registered and change on the same edge as the FSM state/idx, with no combinational path from inputs to outputs.
REQ-027 When NUM_DIGITS=1, idx SHALL stay 0 and every S_ON expiry SHALL be a frame boundary.

Reset
REQ-028 On a rising i_Clk edge with i_Rst_L=0, the block SHALL reset state to S_DEAD, idx=0, counter=0, display and shadow to 0, o_Pending=0, o_Frame_Done=0, o_Digit_En all inactive, and o_Segments all off (polarity per ACTIVE_LOW).
REQ-029 Reset asserted mid-slot or mid-pending SHALL discard the pending shadow value, and after release the scan SHALL restart with DEAD_CYCLES on digit 0.

Verification (bench uses NUM_DIGITS=2, REFRESH_CYCLES=4, DEAD_CYCLES=1, ACTIVE_LOW=1)
REQ-030 The bench SHALL cover: reset, then release -> o_Digit_En=11 and o_Segments=7F for 1 cycle, then o_Digit_En=10 and o_Segments=01 (digit "0", active-low) for 4 cycles, then 11 for 1 cycle, then 01 for 4 cycles; period 10.
REQ-031 The bench SHALL cover: i_Load with i_Value=8'h3A mid-frame -> o_Pending=1 until the frame boundary; the next frame shows digit1 segments 06 (3) and digit0 08 (A); o_Frame_Done pulses once per 10 cycles.
REQ-032 The bench SHALL cover: i_Load 8'h12 then i_Load 8'h45 in the same frame -> only 45 displayed, with no frame showing 12 or a 1/5 mix.
REQ-033 The bench SHALL cover: i_Load asserted on the boundary edge -> the previous shadow is displayed and o_Pending stays 1 until the next boundary.
REQ-034 The bench SHALL cover: value 8'h07 with i_LZ_Blank=1 -> digit1 slot has o_Digit_En=11 and o_Segments=7F, digit0 shows 0F (7); with value 8'h00, digit0 shows 01.
REQ-035 The bench SHALL cover: reset pulsed during digit1 S_ON with a load pending -> outputs dark next cycle, o_Pending=0, and digit0 shows 0 after release.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed hex seven-segment scan driver with dead-time between digit slots,
// frame-synchronous value updates, per-digit blanking and leading-zero blanking.
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned REFRESH_CYCLES = 25000,
    parameter int unsigned DEAD_CYCLES    = 250,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Load,
    input  logic [NUM_DIGITS-1:0]   i_Blank_Mask,
    input  logic                    i_LZ_Blank,
    output logic [6:0]              o_Segments,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Pending,
    output logic                    o_Frame_Done
);

    localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned MAXC = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC);

    localparam logic [CW-1:0] DEAD_LAST    = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    typedef enum logic {S_DEAD, S_ON} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    boundary;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h7E;
            4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;
            4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;
            4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;
            4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;
            4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q      <= S_DEAD;
            idx_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= {7{ACTIVE_LOW}};
            en_q         <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CW'(1);
        boundary = 1'b0;
        case (state_q)
            S_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == REFRESH_LAST) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
        endcase

        // A load on the boundary edge still applies the old shadow; the new value stays pending.
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        disp_d       = disp_q;
        frame_done_d = boundary;
        if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (i_Load) begin
            shadow_d  = i_Value;
            pending_d = 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  all_zero;
    logic [3:0]            nib;
    logic                  dark;
    logic [6:0]            seg_act;
    logic [NUM_DIGITS-1:0] en_act;

    // Outputs are computed from the next state so they register on the same edge as state/idx.
    always_comb begin
        lz_vec   = '0;
        all_zero = 1'b1;
        nib      = '0;
        dark     = 1'b0;
        seg_act  = '0;
        en_act   = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            all_zero = 1'b1;
            for (int unsigned m = k; m < NUM_DIGITS; m++) begin
                all_zero = all_zero & (disp_d[4*m +: 4] == 4'h0);
            end
            lz_vec[k] = (k != 0) && all_zero;
        end
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                nib       = disp_d[4*k +: 4];
                dark      = i_Blank_Mask[k] | (i_LZ_Blank & lz_vec[k]);
                en_act[k] = 1'b1;
            end
        end
        if (state_d == S_ON && !dark) begin
            seg_act = decode(nib);
        end else begin
            en_act = '0;
        end
        seg_d = seg_act ^ {7{ACTIVE_LOW}};
        en_d  = en_act ^ {NUM_DIGITS{ACTIVE_LOW}};
    end

    assign o_Segments   = seg_q;
    assign o_Digit_En   = en_q;
    assign o_Pending    = pending_q;
    assign o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench: per-frame expected digit/segment/flag samples are queued, then popped
// and compared once per clock on the falling edge.
module tb_seven_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [7:0] value;
    logic       load;
    logic [1:0] blank_mask;
    logic       lz_blank;
    logic [6:0] segments;
    logic [1:0] digit_en;
    logic       pending;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] en;
        logic [6:0] seg;
        logic       fd;
        logic       pend;
    } item_t;

    item_t sb[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS(2),
        .REFRESH_CYCLES(4),
        .DEAD_CYCLES(1),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_l),
        .i_Value(value),
        .i_Load(load),
        .i_Blank_Mask(blank_mask),
        .i_LZ_Blank(lz_blank),
        .o_Segments(segments),
        .o_Digit_En(digit_en),
        .o_Pending(pending),
        .o_Frame_Done(frame_done)
    );

    always #5 clk = ~clk;

    // Active-low segment patterns.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h7E; 4'h1: hi = 7'h30; 4'h2: hi = 7'h6D; 4'h3: hi = 7'h79;
            4'h4: hi = 7'h33; 4'h5: hi = 7'h5B; 4'h6: hi = 7'h5F; 4'h7: hi = 7'h70;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h7B; 4'hA: hi = 7'h77; 4'hB: hi = 7'h1F;
            4'hC: hi = 7'h4E; 4'hD: hi = 7'h3D; 4'hE: hi = 7'h4F; default: hi = 7'h47;
        endcase
        return ~hi;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample 0 is the dead slot after the frame boundary, 1-4 digit0, 5 dead, 6-9 digit1.
    task automatic push_frame(input logic [7:0] v, input bit lz, input logic [1:0] mask,
                              input bit fd0, input bit p0, input int pend_from);
        for (int s = 0; s < 10; s++) begin
            item_t it;
            it.fd   = (s == 0) ? fd0 : 1'b0;
            it.pend = p0 | (s >= pend_from);
            if (s >= 1 && s <= 4 && !mask[0]) begin
                it.en  = 2'b10;
                it.seg = seg_of(v[3:0]);
            end else if (s >= 6 && !mask[1] && !(lz && v[7:4] == 4'h0)) begin
                it.en  = 2'b01;
                it.seg = seg_of(v[7:4]);
            end else begin
                it.en  = 2'b11;
                it.seg = 7'h7F;
            end
            sb.push_back(it);
        end
    endtask

    task automatic run_frame(input bit wait_fd, input int la, input logic [7:0] va,
                             input int lb, input logic [7:0] vb);
        int n;
        item_t it;
        n = 0;
        if (wait_fd) begin
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                n++;
                if (frame_done === 1'b1) break;
            end
            chk("frame_wait", 16'(n), 16'd1);
        end else begin
            @(negedge clk);
        end
        for (int s = 0; s < 10; s++) begin
            if (s > 0) @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", 16'd1, 16'd0);
            end else begin
                it = sb.pop_front();
                chk($sformatf("en_s%0d", s), 16'(digit_en), 16'(it.en));
                chk($sformatf("seg_s%0d", s), 16'(segments), 16'(it.seg));
                chk($sformatf("fd_s%0d", s), 16'(frame_done), 16'(it.fd));
                chk($sformatf("pend_s%0d", s), 16'(pending), 16'(it.pend));
            end
            load = (s == la) || (s == lb);
            if (s == lb) value = vb;
            else if (s == la) value = va;
        end
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    initial begin
        rst_l      = 1'b0;
        value      = 8'h00;
        load       = 1'b0;
        blank_mask = 2'b00;
        lz_blank   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 16'(digit_en), 16'h3);
        chk("rst_seg", 16'(segments), 16'h7F);
        chk("rst_pend", 16'(pending), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);

        // Post-reset frame showing 00; 3A loaded mid-frame.
        @(posedge clk);
        #1 rst_l = 1'b1;
        push_frame(8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 3);
        run_frame(1'b0, 2, 8'h3A, -1, 8'h00);

        // 3A shown; 12 then 45 loaded in the same frame.
        lz_blank = 1'b1;
        push_frame(8'h3A, 1'b1, 2'b00, 1'b1, 1'b0, 3);
        run_frame(1'b1, 2, 8'h12, 5, 8'h45);

        // Only 45 shown; 07 loaded mid-frame, then 00 on the boundary edge.
        push_frame(8'h45, 1'b1, 2'b00, 1'b1, 1'b0, 4);
        run_frame(1'b1, 3, 8'h07, 9, 8'h00);

        // 07 applied with leading-zero blanking; 00 still pending.
        push_frame(8'h07, 1'b1, 2'b00, 1'b1, 1'b1, 0);
        run_frame(1'b1, -1, 8'h00, -1, 8'h00);

        // 00 applied: digit1 blanked, digit0 never blanked.
        push_frame(8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 10);
        run_frame(1'b1, -1, 8'h00, -1, 8'h00);

        // Live blank mask on digit0, leading-zero blanking off.
        lz_blank   = 1'b0;
        blank_mask = 2'b01;
        push_frame(8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 10);
        run_frame(1'b1, -1, 8'h00, -1, 8'h00);

        // Reset during digit1 lit slot with 99 pending.
        blank_mask = 2'b00;
        begin
            int n;
            n = 0;
            for (int t = 0; t < 30; t++) begin
                @(negedge clk);
                n++;
                if (frame_done === 1'b1) break;
            end
            chk("rst_frame_wait", 16'(n), 16'd1);
        end
        @(negedge clk);
        @(negedge clk);
        value = 8'h99;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_en", 16'(digit_en), 16'h1);
        chk("pre_rst_pend", 16'(pending), 16'h1);
        rst_l = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", 16'(digit_en), 16'h3);
        chk("mid_rst_seg", 16'(segments), 16'h7F);
        chk("mid_rst_pend", 16'(pending), 16'h0);
        chk("mid_rst_fd", 16'(frame_done), 16'h0);
        @(posedge clk);
        #1 rst_l = 1'b1;
        push_frame(8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 10);
        run_frame(1'b0, -1, 8'h00, -1, 8'h00);

        // Display stays 00 afterwards: the discarded 99 never appears.
        push_frame(8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 10);
        run_frame(1'b1, -1, 8'h00, -1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
